// File: rtl/melody_sequencer.sv
// Note-ROM melody player feeding the Buzzer music_scale input.
// Each entry is a timed note followed by a fixed articulation gap.
module melody_sequencer #(
  parameter int TICK_CYCLES = 6_250_000,
  parameter int GAP_CYCLES  = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [1:0] i_song_sel,
  input  logic       i_loop,
  input  logic       i_stop,
  output logic [5:0] o_music_scale,
  output logic       o_busy,
  output logic       o_done
);

  localparam int CW = $clog2(15 * TICK_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_NOTE  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam logic [CW-1:0] TICK_W   = CW'(TICK_CYCLES);
  localparam logic [CW-1:0] GAP_ADJ  = CW'(GAP_CYCLES + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  logic [1:0]    state;
  logic [3:0]    addr;
  logic [3:0]    base;
  logic          loop_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] note_last;

  logic [9:0]    rom_word;
  logic [5:0]    rom_note;
  logic [3:0]    rom_dur;
  logic [3:0]    sel_base;
  logic [CW-1:0] dur_last;

  always_comb begin
    rom_word = 10'd0;
    case (addr)
      4'd0:    rom_word = {6'd8,  4'd2};
      4'd1:    rom_word = {6'd9,  4'd2};
      4'd2:    rom_word = {6'd10, 4'd2};
      4'd3:    rom_word = {6'd8,  4'd2};
      4'd5:    rom_word = {6'd12, 4'd1};
      4'd6:    rom_word = {6'd10, 4'd1};
      4'd7:    rom_word = {6'd8,  4'd4};
      4'd9:    rom_word = {6'd15, 4'd1};
      default: rom_word = 10'd0;
    endcase
  end

  assign rom_note = rom_word[9:4];
  assign rom_dur  = rom_word[3:0];

  // Last count of the audible part: dur*TICK - GAP clocks.
  assign dur_last = CW'(rom_dur) * TICK_W - GAP_ADJ;

  always_comb begin
    sel_base = 4'd0;
    case (i_song_sel)
      2'd0:    sel_base = 4'd0;
      2'd1:    sel_base = 4'd5;
      2'd2:    sel_base = 4'd9;
      default: sel_base = 4'd11;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      addr          <= 4'd0;
      base          <= 4'd0;
      loop_q        <= 1'b0;
      cnt           <= '0;
      note_last     <= '0;
      o_music_scale <= 6'd0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_stop) begin
        state         <= S_IDLE;
        cnt           <= '0;
        o_music_scale <= 6'd0;
        o_busy        <= 1'b0;
      end else if (i_start) begin
        state         <= S_FETCH;
        addr          <= sel_base;
        base          <= sel_base;
        loop_q        <= i_loop;
        cnt           <= '0;
        o_music_scale <= 6'd0;
        o_busy        <= 1'b1;
      end else begin
        unique case (state)
          S_FETCH: begin
            cnt <= '0;
            if (rom_dur != 4'd0) begin
              state         <= S_NOTE;
              note_last     <= dur_last;
              o_music_scale <= rom_note;
            end else if (loop_q && addr != base) begin
              addr <= base;
            end else begin
              // Empty song ends here even with loop set.
              state  <= S_IDLE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end
          end
          S_NOTE: begin
            if (cnt == note_last) begin
              state         <= S_GAP;
              cnt           <= '0;
              o_music_scale <= 6'd0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_GAP: begin
            if (cnt == GAP_LAST) begin
              state <= S_FETCH;
              addr  <= addr + 4'd1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays short melodies from an internal note ROM and drives the 6-bit `music_scale` code consumed by `Buzzer`. Game logic selects a song (background loop, game-over jingle, score blip, silence) and pulses start. The sequencer steps through note/duration entries at a fixed tick rate, inserts an articulation gap of silence after every note, and reports busy/done. It is the stage directly upstream of `Buzzer`, and `o_music_scale` connects straight to that block's `music_scale` input.

## Interface

**Parameters**
- `TICK_CYCLES`, default 6_250_000: clocks per duration tick (8 Hz at 50 MHz).
- `GAP_CYCLES`, default 500_000: trailing silence per note in clocks.
  - Legal range: 1 ≤ `GAP_CYCLES` < `TICK_CYCLES`.

**Ports**
- `clk`  in  1: system clock, 50 MHz.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `i_start`  in  1: start request, sampled every edge.
- `i_song_sel`  in  2: song index, sampled with `i_start`.
- `i_loop`  in  1: loop enable, sampled with `i_start`.
- `i_stop`  in  1: abort playback.
- `o_music_scale`  out  6: note code; 0 = rest, 1..21 = C_LOW..B_HIGH.
- `o_busy`  out  1: playback in progress.
- `o_done`  out  1: one-cycle pulse on natural song completion.

## Operation

**ROM.** 16 entries, 4-bit address. Each entry is {note[5:0], dur[3:0]}; `dur` = 0 is the end marker. All unlisted addresses hold end markers.
- Song 0, base 0: (8,2) (9,2) (10,2) (8,2), end at 4.
- Song 1, base 5: (12,1) (10,1) (8,4), end at 8.
- Song 2, base 9: (15,1), end at 10.
- Song 3, base 11: end marker only (empty song).

**States:** IDLE, FETCH, NOTE, GAP.
- **IDLE.** Output 0, `o_busy`=0.
  - `i_start` → FETCH with addr = base(`i_song_sel`); `i_loop` is latched.
- **FETCH** (exactly 1 cycle). Output 0. Reads ROM[addr].
  - `dur` ≠ 0 → NOTE, `o_music_scale` = note.
  - `dur` = 0 with latched loop set and addr ≠ base → FETCH again with addr = base.
  - `dur` = 0 otherwise → IDLE with `o_done` pulse. This covers the empty song even when loop is set, so the sequencer never spins.
- **NOTE.** Holds the note for `dur`×`TICK_CYCLES` − `GAP_CYCLES` clocks, then → GAP.
- **GAP.** Output 0 for `GAP_CYCLES` clocks, then → FETCH with addr+1. The address wraps mod 16, which is unreachable with the ROM above.
- **Entry period:** each entry occupies 1 + `dur`×`TICK_CYCLES` clocks.

**Control priority.** `i_stop` > `i_start` > sequencing.
- `i_stop` in any state → IDLE next edge, output 0, no `o_done`.
- `i_start` while busy restarts immediately with the new song and loop setting, with no `o_done` for the preempted song.
- `i_start` and `i_stop` on the same edge → IDLE.
- Note 0 in the ROM is a legal timed rest.

**Counters.** The clock counter is sized for `dur`×`TICK_CYCLES`, i.e. ≥ 27 bits at defaults. Counters are cleared on every state entry, with no carry between entries.

## Timing

- **Reset:** state IDLE, addr 0, `o_music_scale`=0, `o_busy`=0, `o_done`=0, loop latch 0, all counters 0.
- **All outputs are registered.** `o_busy` is 1 in FETCH/NOTE/GAP.
- **Latency:** edge E samples `i_start`. After E the state is FETCH and `o_busy`=1. After E+1 the first note appears.
- **Done:** the edge that leaves the end-marker FETCH sets `o_done`=1 and `o_busy`=0 together. `o_done` clears on the next edge.
- **Gap:** `o_music_scale` returns to 0 between every pair of notes for at least `GAP_CYCLES`+1 clocks, so repeated identical notes are audible as separate notes.

## Test plan

Parameters: `TICK_CYCLES`=10, `GAP_CYCLES`=2. "After k" means after k edges, counted from the edge that sampled `i_start`.

1. **Song 0, no loop.**
   - Stimulus: start with `i_song_sel`=0, `i_loop`=0.
   - Response: note 8 during after-2..after-19, then 0 for two clocks, then 0 for FETCH; note 9 from after-23; notes 10 and 8 follow at the same 21-cycle period; `o_done`=1 only at after-86, with `o_busy` falling at after-86.
2. **Song 0 with loop.**
   - Stimulus: start with `i_loop`=1.
   - Response: after the end marker at after-85, the next FETCH occurs and note 8 reappears at after-87; no `o_done` is ever seen; `i_stop` then gives output 0 and `o_busy`=0 one edge later, with no done pulse.
3. **Empty song.**
   - Stimulus: song 3 with `i_loop`=1.
   - Response: `o_busy` is 1 for exactly one cycle (after-1), `o_done` pulses at after-2, output stays 0 throughout.
4. **Preemption.**
   - Stimulus: song 0 playing; at after-30 start song 2.
   - Response: FETCH at base 9, note 15 for 8 clocks, gap, then done; song 0 produces no done pulse.
5. **Simultaneous start and stop.**
   - Stimulus: `i_start` and `i_stop` high on the same edge while song 1 plays.
   - Response: IDLE, output 0, no `o_done`.
6. **Async reset mid-note.**
   - Stimulus: assert `rst_n`=0 during song 1's note 12.
   - Response: `o_music_scale`=0 and `o_busy`=0 immediately, without waiting for a clock; after release the block stays idle until the next `i_start`.
